// File: rtl/ins_fetch_ctrl_if.sv
// ins_fetch_ctrl_if: groups the fetch controller's memory, decode and redirect signals.
//   master : the fetch controller (drives mem_req/mem_addr, out_*, misalign_err, halted)
//   slave  : the surrounding system (drives fetch_en, mem_rdata, out_ready, redirect_*)
// Signals:
//   fetch_en        allows new fetch issue
//   mem_req         issue strobe, mem_addr valid this cycle
//   mem_addr  [32]  word-aligned byte address to instruction memory
//   mem_rdata [32]  instruction word, valid the cycle after mem_req
//   out_valid       head of the output buffer is valid
//   out_ready       decode accepts the head
//   out_instr [32]  head instruction
//   out_pc    [32]  PC of the head instruction
//   redirect_valid  one-cycle branch/jump redirect request
//   redirect_pc [32] redirect target
//   misalign_err    one-cycle pulse after a misaligned redirect target
//   halted          controller is halted at end of image
interface ins_fetch_ctrl_if;
  logic        fetch_en;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic        halted;

  modport master (
    input  fetch_en, mem_rdata, out_ready, redirect_valid, redirect_pc,
    output mem_req, mem_addr, out_valid, out_instr, out_pc, misalign_err, halted
  );

  modport slave (
    output fetch_en, mem_rdata, out_ready, redirect_valid, redirect_pc,
    input  mem_req, mem_addr, out_valid, out_instr, out_pc, misalign_err, halted
  );
endinterface

// File: rtl/ins_fetch_ctrl.sv
// ins_fetch_ctrl: instruction fetch sequencer. Owns the PC, issues word reads to
// an instruction memory with 1-cycle read latency, and buffers {pc, instr} in a
// small FIFO toward decode. Handles redirects, fetch enable and end-of-image halt.
// Ports:
//   del_clk  clock, all state updates on posedge
//   rst      synchronous active-high reset
//   bus      ins_fetch_ctrl_if.master (memory, decode and redirect signals)
// mem_req/mem_addr are combinational (issue decision and current PC); out_* are
// read straight from the FIFO registers.
module ins_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned MEM_BYTES  = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic              del_clk,
  input logic              rst,
  ins_fetch_ctrl_if.master bus
);

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             misalign_q, misalign_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     fifo_q [FIFO_DEPTH];

  logic        out_valid_c;
  logic        issue_c;
  logic        push_c;
  logic        pop_c;
  logic [31:0] pc_inc_c;
  logic [31:0] redir_pc_c;
  logic        redir_in_range_c;
  logic [31:0] occupancy_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue decision, FIFO bookkeeping, PC update and FSM next state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    out_valid_c      = (count_q != '0);
    pop_c            = out_valid_c & bus.out_ready;
    pc_inc_c         = pc_q + 32'd4;
    redir_pc_c       = {bus.redirect_pc[31:2], 2'b00};
    redir_in_range_c = (redir_pc_c < MEM_LIMIT);
    // Credit check: entries held plus the word still in flight, less this cycle's pop.
    occupancy_c      = 32'(count_q) + 32'(inflight_q) - 32'(pop_c);
    issue_c          = (state_q == ST_RUN) & ~bus.redirect_valid
                       & (occupancy_c < 32'(FIFO_DEPTH));
    // A redirect squashes the word returning this cycle.
    push_c           = inflight_q & ~bus.redirect_valid;

    inflight_d    = issue_c;
    inflight_pc_d = issue_c ? pc_q : inflight_pc_q;
    misalign_d    = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);

    if (bus.redirect_valid) begin
      pc_d     = redir_pc_c;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (!redir_in_range_c) begin
        state_d = ST_HALT;
      end else if (state_q == ST_HALT || bus.fetch_en) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      if (issue_c) pc_d = pc_inc_c;

      unique case (state_q)
        ST_IDLE: begin
          if (bus.fetch_en) state_d = ST_RUN;
        end
        ST_RUN: begin
          // End-of-image takes precedence over a fetch_en drop in the same cycle.
          if ((issue_c && (pc_inc_c >= MEM_LIMIT)) || (!issue_c && (pc_q >= MEM_LIMIT))) begin
            state_d = ST_HALT;
          end else if (!bus.fetch_en) begin
            state_d = ST_IDLE;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge del_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      misalign_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misalign_q    <= misalign_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful where count_q says so.
  always_ff @(posedge del_clk) begin
    if (push_c && !rst) begin
      fifo_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: bus.mem_rdata};
    end
  end

  assign bus.mem_req      = issue_c;
  assign bus.mem_addr     = pc_q;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_instr    = fifo_q[rd_ptr_q].instr;
  assign bus.out_pc       = fifo_q[rd_ptr_q].pc;
  assign bus.misalign_err = misalign_q;
  assign bus.halted       = (state_q == ST_HALT);

endmodule
